// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Moore control FSM for a shared multicycle MIPS datapath
//                (R-type, lw, sw, beq, addi, j). One step per clock, stalls
//                on the mem_ready handshake, aborts to FETCH on wait timeout.
//                Optional macro BNE_EN adds bne (opcode 000101) via BRANCH.
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic       RegWrite,
    output logic       AluSrcA,
    output logic [1:0] AluSrcB,
    output logic [1:0] AluOp,
    output logic [1:0] PCSrc,
    output logic       pc_en,
    output logic       instr_done,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    localparam int                 c_CNT_W      = $clog2(MEM_WAIT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LIMIT = c_CNT_W'(MEM_WAIT_MAX);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
`ifdef BNE_EN
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
`endif

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    // Pure state-decoded controls; the handshake-gated ones are built below.
    typedef struct packed {
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       regDst;
        logic       memToReg;
        logic       regWrite;
        logic       aluSrcA;
        logic [1:0] aluSrcB;
        logic [1:0] aluOp;
        logic [1:0] pcSrc;
    } ctrl_t;

    state_t              r_state;
    state_t              w_nextState;
    ctrl_t               r_ctrl;
    logic [c_CNT_W-1:0]  r_waitCnt;
    logic                w_waiting;
    logic                w_timeout;
    logic                w_illegal;
    logic                w_branchTake;
    logic                w_run;

    // Control word for a given state; unlisted fields stay 0.
    function automatic ctrl_t decodeCtrl(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            FETCH: begin
                c.memRead = 1'b1;
                c.aluSrcB = 2'b01;
            end
            DECODE: c.aluSrcB = 2'b11;
            MEMADR: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
            end
            MEMRD: begin
                c.iorD    = 1'b1;
                c.memRead = 1'b1;
            end
            MEMWB: begin
                c.memToReg = 1'b1;
                c.regWrite = 1'b1;
            end
            MEMWR: begin
                c.iorD     = 1'b1;
                c.memWrite = 1'b1;
            end
            EXEC: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = 2'b10;
            end
            ALUWB: begin
                c.regDst   = 1'b1;
                c.regWrite = 1'b1;
            end
            BRANCH: begin
                c.aluSrcA = 1'b1;
                c.aluOp   = 2'b01;
                c.pcSrc   = 2'b01;
            end
            ADDIEX: begin
                c.aluSrcA = 1'b1;
                c.aluSrcB = 2'b10;
            end
            ADDIWB: c.regWrite = 1'b1;
            JUMP:   c.pcSrc = 2'b10;
            default: c = '0;
        endcase
        return c;
    endfunction

    // Memory-wait bookkeeping: only the three handshake states can stall.
    assign w_waiting = ((r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR))
                       && !mem_ready;
    assign w_timeout = w_waiting && (r_waitCnt == c_WAIT_LIMIT);

`ifdef BNE_EN
    logic r_branchNe;
    assign w_branchTake = r_branchNe ? ~zero : zero;
`else
    assign w_branchTake = zero;
`endif

    // Next-state selection from current state, opcode and handshake.
    always_comb begin
        w_nextState = r_state;
        w_illegal   = 1'b0;
        case (r_state)
            FETCH:  if (mem_ready) w_nextState = DECODE;
            DECODE: begin
                case (opcode)
                    c_OP_LW, c_OP_SW: w_nextState = MEMADR;
                    c_OP_RTYPE:       w_nextState = EXEC;
                    c_OP_BEQ:         w_nextState = BRANCH;
                    c_OP_ADDI:        w_nextState = ADDIEX;
                    c_OP_J:           w_nextState = JUMP;
`ifdef BNE_EN
                    c_OP_BNE:         w_nextState = BRANCH;
`endif
                    default: begin
                        w_illegal   = 1'b1;
                        w_nextState = FETCH;
                    end
                endcase
            end
            MEMADR: w_nextState = (opcode == c_OP_LW) ? MEMRD : MEMWR;
            MEMRD:  if (mem_ready) w_nextState = MEMWB;
            MEMWR:  if (mem_ready) w_nextState = FETCH;
            EXEC:   w_nextState = ALUWB;
            ADDIEX: w_nextState = ADDIWB;
            MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: w_nextState = FETCH;
            default: w_nextState = FETCH;
        endcase
        // A timeout abandons the instruction; from FETCH this is a retry.
        if (w_timeout) w_nextState = FETCH;
    end

    // State, registered control word, wait counter and branch-sense flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= FETCH;
            r_ctrl    <= decodeCtrl(FETCH);
            r_waitCnt <= '0;
`ifdef BNE_EN
            r_branchNe <= 1'b0;
`endif
        end else begin
            r_state <= w_nextState;
            r_ctrl  <= decodeCtrl(w_nextState);
            if ((w_nextState != r_state) || w_timeout) begin
                r_waitCnt <= '0;
            end else if (w_waiting) begin
                r_waitCnt <= r_waitCnt + c_CNT_ONE;
            end
`ifdef BNE_EN
            // BRANCH always lasts one cycle, so this also clears on leaving it.
            r_branchNe <= (r_state == DECODE) && (opcode == c_OP_BNE);
`endif
        end
    end

    // Reset holds every output low, including the handshake-gated enables.
    assign w_run = ~reset;

    assign IorD     = r_ctrl.iorD     & w_run;
    assign MemRead  = r_ctrl.memRead  & w_run;
    assign MemWrite = r_ctrl.memWrite & ~w_timeout & w_run;
    assign RegDst   = r_ctrl.regDst   & w_run;
    assign MemToReg = r_ctrl.memToReg & w_run;
    assign RegWrite = r_ctrl.regWrite & w_run;
    assign AluSrcA  = r_ctrl.aluSrcA  & w_run;
    assign AluSrcB  = r_ctrl.aluSrcB  & {2{w_run}};
    assign AluOp    = r_ctrl.aluOp    & {2{w_run}};
    assign PCSrc    = r_ctrl.pcSrc    & {2{w_run}};

    assign IRWrite = w_run && (r_state == FETCH) && mem_ready;
    assign pc_en   = w_run && (((r_state == FETCH) && mem_ready)
                               || (r_state == JUMP)
                               || ((r_state == BRANCH) && w_branchTake));

    assign instr_done = w_run && ((r_state == MEMWB) || (r_state == ALUWB)
                                  || (r_state == ADDIWB) || (r_state == BRANCH)
                                  || (r_state == JUMP)
                                  || ((r_state == MEMWR) && mem_ready));

    assign illegal_op  = w_run && w_illegal;
    assign mem_timeout = w_run && w_timeout;
    assign state       = w_run ? 4'(r_state) : 4'd0;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control. An instruction-
//                level model expands each opcode and its memory wait plan into
//                the expected per-cycle state and control outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

    localparam int MAXW = 4;
`ifdef BNE_EN
    localparam bit BNE = 1'b1;
`else
    localparam bit BNE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, AluSrcA;
    logic [1:0] AluSrcB, AluOp, PCSrc;
    logic       pc_en, instr_done, illegal_op, mem_timeout;
    logic [3:0] state;
    logic [21:0] obs;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_WAIT_MAX(MAXW)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite), .AluSrcA(AluSrcA),
        .AluSrcB(AluSrcB), .AluOp(AluOp), .PCSrc(PCSrc), .pc_en(pc_en),
        .instr_done(instr_done), .illegal_op(illegal_op), .mem_timeout(mem_timeout),
        .state(state)
    );

    assign obs = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, AluSrcA,
                  AluSrcB, AluOp, PCSrc, pc_en, instr_done, illegal_op, mem_timeout, state};

    function automatic bit isLegal(input logic [5:0] op);
        return (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04)
            || (op == 6'h08) || (op == 6'h02) || (BNE && (op == 6'h05));
    endfunction

    // Expected outputs for one cycle spent in step st of the instruction.
    function automatic logic [21:0] expVec(input int st, input bit rdy, input bit z,
                                           input logic [5:0] op, input bit tmo);
        logic iorD, memRd, memWr, irW, regDst, m2r, regW, srcA, pcEn, done, ill, mt;
        logic [1:0] srcB, aluOp, pcSrc;
        {iorD, memRd, memWr, irW, regDst, m2r, regW, srcA, pcEn, done, ill, mt} = '0;
        srcB = 2'b00; aluOp = 2'b00; pcSrc = 2'b00;
        case (st)
            0:  begin memRd = 1; srcB = 2'b01; irW = rdy; pcEn = rdy; mt = tmo; end
            1:  begin srcB = 2'b11; ill = !isLegal(op); end
            2:  begin srcA = 1; srcB = 2'b10; end
            3:  begin iorD = 1; memRd = 1; mt = tmo; end
            4:  begin m2r = 1; regW = 1; done = 1; end
            5:  begin iorD = 1; memWr = !tmo; done = rdy; mt = tmo; end
            6:  begin srcA = 1; aluOp = 2'b10; end
            7:  begin regDst = 1; regW = 1; done = 1; end
            8:  begin
                    srcA = 1; aluOp = 2'b01; pcSrc = 2'b01; done = 1;
                    pcEn = (BNE && op == 6'h05) ? !z : z;
                end
            9:  begin srcA = 1; srcB = 2'b10; end
            10: begin regW = 1; done = 1; end
            11: begin pcSrc = 2'b10; pcEn = 1; done = 1; end
            default: ;
        endcase
        return {iorD, memRd, memWr, irW, regDst, m2r, regW, srcA, srcB, aluOp, pcSrc,
                pcEn, done, ill, mt, 4'(st)};
    endfunction

    // One clock: drive handshake inputs, check at the falling edge, advance.
    task automatic cyc(input int st, input bit rdy, input bit z, input bit tmo);
        logic [21:0] e;
        mem_ready = rdy;
        zero      = z;
        @(negedge clk);
        e = expVec(st, rdy, z, opcode, tmo);
        nChecks++;
        assert (obs === e) else begin
            nFails++;
            $error("FAIL step%0d op=%h rdy=%0b: observed %h expected %h", st, opcode, rdy, obs, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic doReset(input int n);
        reset = 1'b1;
        for (int k = 0; k < n; k++) begin
            mem_ready = 1'b1;
            zero      = 1'($urandom_range(0, 1));
            @(negedge clk);
            nChecks++;
            assert (obs === 22'd0) else begin
                nFails++;
                $error("FAIL reset_outputs: observed %h expected %h", obs, 22'd0);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    // waits <= MAXW: that many stalled cycles then a ready cycle.
    // waits  > MAXW: MAXW+1 stalled cycles, the last one times out.
    task automatic memPhase(input int st, input int waits, input bit z, output bit aborted);
        aborted = 1'b0;
        if (waits > MAXW) begin
            for (int k = 0; k <= MAXW; k++) cyc(st, 1'b0, z, k == MAXW);
            aborted = 1'b1;
        end else begin
            for (int k = 0; k < waits; k++) cyc(st, 1'b0, z, 1'b0);
            cyc(st, 1'b1, z, 1'b0);
        end
    endtask

    task automatic runInstr(input logic [5:0] op, input bit z, input int wf, input int wm);
        bit ab;
        opcode = op;
        memPhase(0, wf, z, ab);
        if (ab) return;
        cyc(1, 1'($urandom_range(0, 1)), z, 1'b0);
        if (!isLegal(op)) return;
        case (op)
            6'h23: begin
                cyc(2, 1'($urandom_range(0, 1)), z, 1'b0);
                memPhase(3, wm, z, ab);
                if (!ab) cyc(4, 1'($urandom_range(0, 1)), z, 1'b0);
            end
            6'h2B: begin
                cyc(2, 1'($urandom_range(0, 1)), z, 1'b0);
                memPhase(5, wm, z, ab);
            end
            6'h00: begin
                cyc(6, 1'($urandom_range(0, 1)), z, 1'b0);
                cyc(7, 1'($urandom_range(0, 1)), z, 1'b0);
            end
            6'h08: begin
                cyc(9, 1'($urandom_range(0, 1)), z, 1'b0);
                cyc(10, 1'($urandom_range(0, 1)), z, 1'b0);
            end
            6'h02: cyc(11, 1'($urandom_range(0, 1)), z, 1'b0);
            default: cyc(8, 1'($urandom_range(0, 1)), z, 1'b0);
        endcase
    endtask

    initial begin
        logic [5:0] ops [0:6];
        logic [5:0] op;
        int wf, wm;
        ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04;
        ops[4] = 6'h08; ops[5] = 6'h02; ops[6] = 6'h05;
        reset = 1'b1; opcode = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1;
        doReset(2);

        // Directed walk through every instruction class.
        runInstr(6'h00, 1'b0, 0, 0);
        runInstr(6'h23, 1'b1, 0, 0);
        runInstr(6'h2B, 1'b0, 0, 0);
        runInstr(6'h08, 1'b0, 0, 0);
        runInstr(6'h04, 1'b1, 0, 0);
        runInstr(6'h04, 1'b0, 0, 0);
        runInstr(6'h02, 1'b0, 0, 0);
        runInstr(6'h23, 1'b0, 0, 3);          // lw with three stalled cycles
        runInstr(6'h2B, 1'b0, 0, MAXW + 1);   // sw times out
        runInstr(6'h05, 1'b0, 0, 0);          // bne or illegal, by build
        runInstr(6'h3F, 1'b0, 0, 0);          // illegal opcode
        runInstr(6'h00, 1'b0, MAXW + 1, 0);   // fetch timeout then retry
        runInstr(6'h00, 1'b1, MAXW, 0);       // fetch waits right up to the limit
        runInstr(6'h23, 1'b0, 0, MAXW + 1);   // lw times out in the read

        // Reset while a store is waiting drops the write.
        opcode = 6'h2B;
        cyc(0, 1'b1, 1'b0, 1'b0);
        cyc(1, 1'b1, 1'b0, 1'b0);
        cyc(2, 1'b1, 1'b0, 1'b0);
        cyc(5, 1'b0, 1'b0, 1'b0);
        cyc(5, 1'b0, 1'b0, 1'b0);
        doReset(1);
        runInstr(6'h2B, 1'b1, 0, MAXW);       // counter restarts from zero

        // Randomized instruction stream.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 7) == 0) op = 6'($urandom);
            else                           op = ops[$urandom_range(0, 6)];
            wf = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, MAXW + 1)) : 0;
            wm = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, MAXW + 1)) : 0;
            runInstr(op, 1'($urandom_range(0, 1)), wf, wm);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style control FSM that sequences the shared multicycle MIPS datapath: one memory port, one ALU, instruction register, PC and register file.
- Decodes the instruction opcode and steps each instruction through Fetch/Decode/Execute/Memory/Writeback, one step per clock.
- Stalls on a memory ready handshake and recovers from memory timeouts.
- Supports R-type, lw, sw, beq, addi and j.

Parameters:
- MEM_WAIT_MAX, 15: maximum cycles spent waiting for mem_ready in a memory state before timeout. Legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instr[31:26] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register select: 1=rd, 0=rt
- MemToReg  out  1  writeback source: 1=MDR, 0=ALUOut
- RegWrite  out  1  register file write
- AluSrcA  out  1  ALU A input: 0=PC, 1=rs
- AluSrcB  out  2  ALU B input: 00=rt, 01=4, 10=signext, 11=signext<<2
- AluOp  out  2  to ALU control: 00=add, 01=sub, 10=funct
- PCSrc  out  2  PC source: 00=ALU, 01=ALUOut, 10=jump target
- pc_en  out  1  PC load enable
- instr_done  out  1  one-cycle pulse on an instruction's final cycle
- illegal_op  out  1  one-cycle pulse, unknown opcode in DECODE
- mem_timeout  out  1  one-cycle pulse, wait limit reached
- state  out  4  current state encoding, for debug

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11. Codes 12-15 are unreachable; they go to FETCH on the next edge with all outputs 0.
- Outputs are a decode of the state. mem_ready and zero gate only IRWrite, pc_en and the pulses.
- Any output not listed for a state is 0.
- FETCH:
  - Drives IorD=0, MemRead=1, AluSrcA=0, AluSrcB=01, AluOp=00, PCSrc=00.
  - IRWrite=pc_en=mem_ready.
  - Goes to DECODE when mem_ready=1, else holds.
- DECODE:
  - Drives AluSrcA=0, AluSrcB=11, AluOp=00.
  - Next state: 100011 or 101011 -> MEMADR; 000000 -> EXEC; 000100 -> BRANCH; 001000 -> ADDIEX; 000010 -> JUMP.
  - Any other opcode: illegal_op=1 and next state FETCH.
- MEMADR: AluSrcA=1, AluSrcB=10, AluOp=00. Next state MEMRD if opcode=100011, else MEMWR.
- MEMRD: IorD=1, MemRead=1. Goes to MEMWB on mem_ready, else holds.
- MEMWB: RegDst=0, MemToReg=1, RegWrite=1, instr_done=1. Next state FETCH.
- MEMWR:
  - IorD=1, MemWrite=1 held until mem_ready.
  - instr_done=mem_ready.
  - Goes to FETCH on mem_ready.
- EXEC: AluSrcA=1, AluSrcB=00, AluOp=10. Next state ALUWB.
- ALUWB: RegDst=1, MemToReg=0, RegWrite=1, instr_done=1. Next state FETCH.
- BRANCH:
  - AluSrcA=1, AluSrcB=00, AluOp=01, PCSrc=01.
  - pc_en=zero, instr_done=1.
  - Next state FETCH.
- ADDIEX: AluSrcA=1, AluSrcB=10, AluOp=00. Next state ADDIWB.
- ADDIWB: RegDst=0, MemToReg=0, RegWrite=1, instr_done=1. Next state FETCH.
- JUMP: PCSrc=10, pc_en=1, instr_done=1. Next state FETCH.
- Wait counter:
  - Width $clog2(MEM_WAIT_MAX+1).
  - Cleared on every state change.
  - Increments each cycle in FETCH, MEMRD or MEMWR while mem_ready=0.
- Timeout:
  - Triggers when the counter equals MEM_WAIT_MAX and mem_ready=0.
  - mem_timeout=1 for one cycle, no write enable asserted, next state FETCH with counter cleared. The instruction is aborted; from FETCH this is a retry.
  - If mem_ready=1 in the same cycle, mem_ready wins and there is no timeout.
- Latency with mem_ready tied 1:
  - R-type, addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq, j: 3 cycles.
- Reset:
  - While reset=1, every output is forced to 0, including the gated enables.
  - The first edge with reset=1 loads state=FETCH and clears the counter.
  - Reset mid-instruction aborts it and drops any pending write.
  - FETCH outputs appear on the first cycle after reset is released.

Optional Feature:
- Macro BNE_EN.
- Defined: opcode 000101 goes DECODE -> BRANCH with a registered branch_ne flag set; in BRANCH, pc_en=~zero. The flag clears on leaving BRANCH and on reset.
- Undefined: 000101 is illegal and pulses illegal_op; pc_en in BRANCH is always zero.

Test Plan:
- reset=1 for 2 cycles with mem_ready=1 -> all outputs 0 during reset; first cycle after release: state=0, MemRead=1, IRWrite=1, pc_en=1.
- mem_ready=1, opcode sequence 000000, 100011, 101011, 001000 -> state traces 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5 / 0,1,9,10; RegWrite=1 exactly in states 7, 4 and 10; MemWrite=1 only in state 5; instr_done pulses match.
- beq with zero=1, then beq with zero=0 -> pc_en=1 in BRANCH for the first case, 0 for the second; PCSrc=01 and AluOp=01 in both.
- j -> state 11 with PCSrc=10 and pc_en=1, then state 0.
- lw with mem_ready held 0 in MEMRD for 3 cycles, then 1 -> MEMRD held 4 cycles, then MEMWB, no timeout.
- MEM_WAIT_MAX=4, mem_ready stuck 0 in MEMWR -> mem_timeout pulses on the 5th wait cycle, state goes to 0, MemWrite is 0 after the abort.
- opcode 000101 with zero=0 -> BNE_EN undefined: illegal_op pulse, state 1->0; BNE_EN defined: state 8 with pc_en=1.
